// File: rtl/pxl_st_src_pkg.sv
// ---------------------------------------------------------------------------
// pxl_st_src_pkg
// Shared widths, FSM state type and the skid-buffer word type for the pixel
// stream source (pxl_st_src) and its output skid buffer (pxl_st_skid_buf).
// Optional feature macro used by the design: PXL_ST_ROW_GAP_EN.
// ---------------------------------------------------------------------------
package pxl_st_src_pkg;

    localparam int IMG_WIDTH_IDX_W    = 8;
    localparam int IMG_HEIGHT_IDX_W   = 8;
    localparam int PXL_PRIM_COLOR_W   = 8;
    localparam int PXL_PRIM_COLOR_NUM = 3;
    localparam int MEM_ADDR_W         = IMG_WIDTH_IDX_W + IMG_HEIGHT_IDX_W;
    localparam int PXL_DATA_W         = PXL_PRIM_COLOR_W * PXL_PRIM_COLOR_NUM;
    localparam int ROW_GAP_W          = 4;

    localparam int PXL_ST_SKID_DEPTH  = 2;
    localparam int SKID_PTR_W         = $clog2(PXL_ST_SKID_DEPTH);
    localparam int SKID_CNT_W         = $clog2(PXL_ST_SKID_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        GAP,
        DRAIN,
        DONE
    } pxl_st_src_state_e;

    typedef struct packed {
        logic [PXL_DATA_W-1:0]       data;
        logic [IMG_WIDTH_IDX_W-1:0]  x;
        logic [IMG_HEIGHT_IDX_W-1:0] y;
    } pxl_st_word_t;

endpackage

// File: rtl/pxl_st_src_skid_buf.sv
// ---------------------------------------------------------------------------
// pxl_st_skid_buf
// Two-entry valid/ready FIFO of pxl_st_word_t. The head entry is presented
// from registers, so o_vld never depends on the consumer's ready.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_word : write strobe and word (dropped only if full and no pop)
//   i_pop          : consume head (ignored when empty)
//   o_word, o_vld  : head word and non-empty flag
//   o_count        : current occupancy
// ---------------------------------------------------------------------------
module pxl_st_skid_buf
    import pxl_st_src_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  pxl_st_word_t          i_word,
    input  logic                  i_pop,
    output pxl_st_word_t          o_word,
    output logic                  o_vld,
    output logic [SKID_CNT_W-1:0] o_count
);

    pxl_st_word_t          r_mem [PXL_ST_SKID_DEPTH];
    logic [SKID_PTR_W-1:0] r_wr_ptr;
    logic [SKID_PTR_W-1:0] r_rd_ptr;
    logic [SKID_CNT_W-1:0] r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    // A push into a full buffer is legal only when the head leaves this cycle.
    assign w_push_ok = i_push && ((r_count != SKID_CNT_W'(PXL_ST_SKID_DEPTH)) || w_pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < PXL_ST_SKID_DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_push_ok && (r_wr_ptr == SKID_PTR_W'(gi))) begin
                    r_mem[gi] <= i_word;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + SKID_CNT_W'(w_push_ok) - SKID_CNT_W'(w_pop_ok);
        end
    end

    assign o_word  = r_mem[r_rd_ptr];
    assign o_vld   = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/pxl_st_src.sv
// ---------------------------------------------------------------------------
// pxl_st_src
// Pixel-stream transmitter: on Start, reads a raster frame from a 1-cycle
// latency pixel memory and streams it (x fastest) over a valid/ready port.
// Optional feature macro: PXL_ST_ROW_GAP_EN (idle gap after each row but the
// last, length i_cfg_row_gap sampled on Start). Undefined: rows back-to-back.
// Ports:
//   i_clk, i_rst_n                : clock, asynchronous active-low reset
//   i_start                       : begin frame (ignored unless idle)
//   i_cfg_img_width/height        : frame size, sampled on accepted start
//   i_cfg_row_gap                 : row gap length (feature build only)
//   o_busy, o_done                : frame in progress / 1-cycle completion
//   o_mem_rd_en/addr, i_mem_rd_data : pixel memory read port
//   o_img_width/height            : latched frame size
//   o_pxl_data/x/y/vld, i_pxl_rdy : output pixel stream
// ---------------------------------------------------------------------------
module pxl_st_src
    import pxl_st_src_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [IMG_WIDTH_IDX_W-1:0]  i_cfg_img_width,
    input  logic [IMG_HEIGHT_IDX_W-1:0] i_cfg_img_height,
    input  logic [ROW_GAP_W-1:0]        i_cfg_row_gap,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_mem_rd_en,
    output logic [MEM_ADDR_W-1:0]       o_mem_rd_addr,
    input  logic [PXL_DATA_W-1:0]       i_mem_rd_data,
    output logic [IMG_WIDTH_IDX_W-1:0]  o_img_width,
    output logic [IMG_HEIGHT_IDX_W-1:0] o_img_height,
    output logic [PXL_PRIM_COLOR_W-1:0] o_pxl_data [PXL_PRIM_COLOR_NUM],
    output logic [IMG_WIDTH_IDX_W-1:0]  o_pxl_x,
    output logic [IMG_HEIGHT_IDX_W-1:0] o_pxl_y,
    output logic                        o_pxl_vld,
    input  logic                        i_pxl_rdy
);

    pxl_st_src_state_e           r_state;
    pxl_st_src_state_e           w_state_next;
    logic [IMG_WIDTH_IDX_W-1:0]  r_width;
    logic [IMG_HEIGHT_IDX_W-1:0] r_height;
    logic [IMG_WIDTH_IDX_W-1:0]  r_x;
    logic [IMG_HEIGHT_IDX_W-1:0] r_y;
    logic [MEM_ADDR_W-1:0]       r_addr;
    logic [IMG_WIDTH_IDX_W-1:0]  r_fetch_x;
    logic [IMG_HEIGHT_IDX_W-1:0] r_fetch_y;
    logic                        r_inflight;

    logic [IMG_WIDTH_IDX_W-1:0]  w_width;
    logic [IMG_HEIGHT_IDX_W-1:0] w_height;
    logic                        w_start_ok;
    logic                        w_empty_cfg;
    logic                        w_issue;
    logic                        w_row_end;
    logic                        w_last_rd;
    logic                        w_enter_gap;
    logic                        w_pop;
    logic                        w_room;
    logic [2:0]                  w_occ;
    logic [SKID_CNT_W-1:0]       w_count;
    pxl_st_word_t                w_push_word;
    pxl_st_word_t                w_head;

    assign w_start_ok  = (r_state == IDLE) && i_start;
    assign w_empty_cfg = (i_cfg_img_width == '0) || (i_cfg_img_height == '0);
    // While idle the first read goes out in the Start cycle itself, so the
    // row/frame end tests must use the incoming configuration.
    assign w_width     = (r_state == IDLE) ? i_cfg_img_width  : r_width;
    assign w_height    = (r_state == IDLE) ? i_cfg_img_height : r_height;

    assign w_pop  = o_pxl_vld && i_pxl_rdy;
    // Occupancy after this cycle's pop plus the word landing now; a new read
    // is only safe if that leaves space for its data next cycle.
    assign w_occ  = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_room = (w_occ < 3'd2);

    assign w_issue   = (w_start_ok && !w_empty_cfg) || ((r_state == FETCH) && w_room);
    assign w_row_end = w_issue && (r_x == (w_width - IMG_WIDTH_IDX_W'(1)));
    assign w_last_rd = w_row_end && (r_y == (w_height - IMG_HEIGHT_IDX_W'(1)));

`ifdef PXL_ST_ROW_GAP_EN
    logic [ROW_GAP_W-1:0] r_row_gap;
    logic [ROW_GAP_W-1:0] r_gap_cnt;
    logic [ROW_GAP_W-1:0] w_gap_cfg;

    assign w_gap_cfg   = (r_state == IDLE) ? i_cfg_row_gap : r_row_gap;
    assign w_enter_gap = w_row_end && !w_last_rd && (w_gap_cfg != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_gap <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_start_ok)             r_row_gap <= i_cfg_row_gap;
            if (w_enter_gap)            r_gap_cnt <= w_gap_cfg;
            else if (r_state == GAP)    r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end
`else
    logic w_unused_row_gap;
    assign w_unused_row_gap = ^i_cfg_row_gap;
    assign w_enter_gap      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_mem_rd_en  = w_issue;
        unique case (r_state)
            IDLE: begin
                // An empty frame still passes through DRAIN (no reads, nothing
                // buffered) so Done lands two cycles after Start.
                if (i_start) begin
                    if (w_empty_cfg || w_last_rd) w_state_next = DRAIN;
                    else if (w_enter_gap)         w_state_next = GAP;
                    else                          w_state_next = FETCH;
                end
            end
            FETCH: begin
                o_busy = 1'b1;
                if (w_last_rd)        w_state_next = DRAIN;
                else if (w_enter_gap) w_state_next = GAP;
            end
`ifdef PXL_ST_ROW_GAP_EN
            GAP: begin
                o_busy = 1'b1;
                if (r_gap_cnt <= ROW_GAP_W'(1)) w_state_next = FETCH;
            end
`endif
            DRAIN: begin
                o_busy = 1'b1;
                // Leave in the cycle of the final handshake so Done follows it.
                if (!r_inflight && ((w_count == '0) || ((w_count == SKID_CNT_W'(1)) && w_pop)))
                    w_state_next = DONE;
            end
            DONE: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Running raster counters; the address simply increments because the
    // frame is stored contiguously, which avoids a y*W multiply.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_width    <= '0;
            r_height   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_fetch_x  <= '0;
            r_fetch_y  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_ok) begin
                r_width  <= i_cfg_img_width;
                r_height <= i_cfg_img_height;
            end
            if (w_issue) begin
                r_fetch_x <= r_x;
                r_fetch_y <= r_y;
                if (w_last_rd) begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_addr <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                    if (w_row_end) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
            end
        end
    end

    assign o_mem_rd_addr = r_addr;
    assign o_img_width   = r_width;
    assign o_img_height  = r_height;

    assign w_push_word.data = i_mem_rd_data;
    assign w_push_word.x    = r_fetch_x;
    assign w_push_word.y    = r_fetch_y;

    pxl_st_skid_buf u_skid_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inflight),
        .i_word  (w_push_word),
        .i_pop   (w_pop),
        .o_word  (w_head),
        .o_vld   (o_pxl_vld),
        .o_count (w_count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PXL_PRIM_COLOR_NUM; gi++) begin : g_color
            assign o_pxl_data[gi] = w_head.data[gi*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W];
        end
    endgenerate

    assign o_pxl_x = w_head.x;
    assign o_pxl_y = w_head.y;

endmodule

// File: tb/tb_pxl_st_src.sv
// ---------------------------------------------------------------------------
// tb_pxl_st_src
// Bench for pxl_st_src. A behavioural pixel memory answers reads one cycle
// later; each frame's expected pixel list is built directly from the raster
// rule (x fastest, data = memory word at y*W+x) and compared in order against
// every handshake. Honours PXL_ST_ROW_GAP_EN for the row-gap scenario.
// ---------------------------------------------------------------------------
module tb_pxl_st_src;
    import pxl_st_src_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        start = 1'b0;
    logic [IMG_WIDTH_IDX_W-1:0]  cfg_w = '0;
    logic [IMG_HEIGHT_IDX_W-1:0] cfg_h = '0;
    logic [ROW_GAP_W-1:0]        cfg_gap = '0;
    logic                        busy, done, mem_rd_en;
    logic [MEM_ADDR_W-1:0]       mem_rd_addr;
    logic [PXL_DATA_W-1:0]       mem_rd_data = '0;
    logic [IMG_WIDTH_IDX_W-1:0]  img_w;
    logic [IMG_HEIGHT_IDX_W-1:0] img_h;
    logic [PXL_PRIM_COLOR_W-1:0] pxl_data [PXL_PRIM_COLOR_NUM];
    logic [IMG_WIDTH_IDX_W-1:0]  pxl_x;
    logic [IMG_HEIGHT_IDX_W-1:0] pxl_y;
    logic                        vld;
    logic                        rdy = 1'b0;
    logic [PXL_DATA_W-1:0]       pxl_flat;

    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    logic [7:0]  salt = '0;

    always #5 clk = ~clk;

    pxl_st_src dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_cfg_img_width  (cfg_w),
        .i_cfg_img_height (cfg_h),
        .i_cfg_row_gap    (cfg_gap),
        .o_busy           (busy),
        .o_done           (done),
        .o_mem_rd_en      (mem_rd_en),
        .o_mem_rd_addr    (mem_rd_addr),
        .i_mem_rd_data    (mem_rd_data),
        .o_img_width      (img_w),
        .o_img_height     (img_h),
        .o_pxl_data       (pxl_data),
        .o_pxl_x          (pxl_x),
        .o_pxl_y          (pxl_y),
        .o_pxl_vld        (vld),
        .i_pxl_rdy        (rdy)
    );

    always_comb begin
        pxl_flat = '0;
        for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++)
            pxl_flat[c*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W] = pxl_data[c];
    end

    function automatic logic [PXL_DATA_W-1:0] mem_word(input int addr, input logic [7:0] s);
        return PXL_DATA_W'(addr + 1) ^ (PXL_DATA_W'(s) << 16);
    endfunction

    // Synchronous-read pixel memory, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem_word(int'(mem_rd_addr), salt);
            rd_cnt      <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {vld, busy, done, mem_rd_en, mem_rd_addr, img_w, img_h, pxl_x, pxl_y}, '0);
        chk({tag, "_data"}, 64'(pxl_flat), '0);
    endtask

    // Called at a negedge; drives Start for the coming edge and walks the frame.
    task automatic run_frame(input int w, input int h, input int stall_max, input int gap,
                             input int mid_start_k, input int abort_px);
        logic [39:0] exp_q [$];
        logic [39:0] cur, exp_word, prev_word;
        int npx, rd0, budget, first_vld_k, last_hs_k, done_k, seen, stall_left;
        int bad, idle_run, min_row_gap;
        bit prev_stall, busy_at_done;
        npx = w * h;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back({8'(x), 8'(y), mem_word(y * w + x, salt)});
        budget = npx * (stall_max + 2) + h * (gap + 2) + 20;
        first_vld_k = -1; last_hs_k = -1; done_k = -1; seen = 0; stall_left = 0;
        bad = 0; idle_run = 0; min_row_gap = 1000; prev_stall = 0; prev_word = '0;
        busy_at_done = 1'b1;
        rd0 = rd_cnt;
        cfg_w = 8'(w); cfg_h = 8'(h); cfg_gap = 4'(gap);
        rdy = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= budget && done_k < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == mid_start_k) begin
                start = 1'b1;
                cfg_w = 8'd7;
            end
            cur = {pxl_x, pxl_y, pxl_flat};
            if (done) begin
                done_k = k;
                busy_at_done = busy;
            end else begin
                if (npx > 0 && !busy) bad++;
                if (img_w !== 8'(w) || img_h !== 8'(h)) bad++;
            end
            if (prev_stall) chk("hold_during_stall", {23'd0, vld, cur}, {23'd0, 1'b1, prev_word});
            if (vld) begin
                if (first_vld_k < 0) first_vld_k = k;
                if (pxl_x == '0 && pxl_y != '0 && !prev_stall && idle_run < min_row_gap)
                    min_row_gap = idle_run;
                idle_run = 0;
                rdy = (stall_left == 0);
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_pixel", 64'(cur), 64'(0));
                    end else begin
                        exp_word = exp_q.pop_front();
                        chk($sformatf("px%0d_xyd", seen), 64'(cur), 64'(exp_word));
                    end
                    seen++;
                    last_hs_k = k;
                    stall_left = (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
                    prev_stall = 0;
                    if (abort_px > 0 && seen == abort_px) begin
                        @(negedge clk);
                        rst_n = 1'b0;
                        #1;
                        chk_all_zero("async_reset_outputs");
                        @(negedge clk);
                        rst_n = 1'b1;
                        $display("frame %0dx%0d aborted by reset after %0d pixels", w, h, seen);
                        return;
                    end
                end else begin
                    stall_left--;
                    prev_stall = 1;
                    prev_word = cur;
                end
            end else begin
                idle_run++;
                prev_stall = 0;
                rdy = (stall_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        if (done_k < 0) begin
            chk("done_timeout", 64'(0), 64'(1));
        end else begin
            if (npx > 0) chk("first_vld_latency", 64'(first_vld_k), 64'(2));
            else         chk("no_pixels", 64'(first_vld_k), 64'(-1));
            chk("done_timing", 64'(done_k), (npx > 0) ? 64'(last_hs_k + 1) : 64'(2));
            chk("busy_low_at_done", 64'(busy_at_done), 64'(0));
            chk("pixel_count", 64'(seen), 64'(npx));
            chk("mem_reads", 64'(rd_cnt - rd0), 64'(npx));
            chk("cfg_busy_stable", 64'(bad), 64'(0));
            if (gap > 0 && h > 1) chk("row_gap_len", 64'(min_row_gap >= gap), 64'(1));
        end
        @(negedge clk);
        chk("done_pulse_1cyc", {62'd0, done, busy}, 64'(0));
        $display("frame %0dx%0d stall<=%0d gap=%0d: %0d pixels, done at cycle %0d",
                 w, h, stall_max, gap, seen, done_k);
    endtask

    initial begin
        int w, h, s;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        salt = 8'h00;
        run_frame(3, 2, 0, 0, 0, 0);          // mem[i] = i+1, full rate
        run_frame(3, 2, 2, 0, 0, 0);          // random stalls
        run_frame(0, 5, 0, 0, 0, 0);          // empty frame
        run_frame(3, 2, 1, 0, 3, 0);          // Start while busy with W=7
        salt = 8'($urandom);
        run_frame(1, 1, 2, 0, 0, 0);
        run_frame(1, 4, 0, 0, 0, 0);
        run_frame(5, 1, 3, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            w = int'($urandom_range(1, 9));
            h = int'($urandom_range(1, 6));
            s = int'($urandom_range(0, 3));
            salt = 8'($urandom);
            run_frame(w, h, s, 0, 0, 0);
        end
        salt = 8'h3c;
        run_frame(129, 65, 0, 0, 0, 3);       // reset at pixel 3
        run_frame(129, 65, 0, 0, 0, 0);       // re-send whole frame
`ifdef PXL_ST_ROW_GAP_EN
        run_frame(4, 3, 0, 3, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
